// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, RW encoding and default widths for mem_responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 8;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_LATENCY = 2;
endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: single-port synchronous word storage with a resettable registered read port
module mem_responder_array #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              zero,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  assign idx = addr[IW-1:0];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
  // zero forces an out-of-range read to return 0 instead of an aliased word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= zero ? '0 : mem[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the Addr/RW/Valid/Ready memory handshake with fixed access latency.
// Define MEM_RESPONDER_WAITSTATE_EN to add a per-request WaitCycles extension of the access phase.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] Addr,
  input  logic              RW,
  input  logic              Valid,
  input  logic [DWIDTH-1:0] WData,
`ifdef MEM_RESPONDER_WAITSTATE_EN
  input  logic [3:0]        WaitCycles,
`endif
  output logic [DWIDTH-1:0] RData,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);
  localparam int LAT = LATENCY < 1 ? 1 : LATENCY;
  localparam int CW = $clog2(LAT + 16);
  localparam logic [AWIDTH:0] DEP = (AWIDTH + 1)'(DEPTH);
  state_t state, stateN;
  logic [CW-1:0] cnt, cntLoad;
  logic [AWIDTH-1:0] addrQ;
  logic [DWIDTH-1:0] wdataQ;
  logic rwQ, oorQ, accept, done, finish;
`ifdef MEM_RESPONDER_WAITSTATE_EN
  assign cntLoad = CW'(LAT - 1) + CW'(WaitCycles);
`else
  assign cntLoad = CW'(LAT - 1);
`endif
  always_comb begin
    accept = state == IDLE && Valid;
    done = state == ACCESS && cnt == '0;
    finish = state == HOLD && !Valid;
    stateN = accept ? ACCESS : done ? HOLD : finish ? IDLE : state;
  end
  // oorQ is captured at accept so Err reports the range of the access just completed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addrQ <= '0;
      wdataQ <= '0;
      rwQ <= RW_WRITE;
      oorQ <= 1'b0;
      Ready <= 1'b0;
      Busy <= 1'b0;
      Err <= 1'b0;
    end else begin
      state <= stateN;
      if (accept) begin
        addrQ <= Addr;
        wdataQ <= WData;
        rwQ <= RW;
        oorQ <= {1'b0, Addr} >= DEP;
        cnt <= cntLoad;
        Ready <= 1'b0;
        Err <= 1'b0;
        Busy <= 1'b1;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        Ready <= 1'b1;
        Busy <= 1'b0;
        Err <= oorQ;
      end
    end
  end
  mem_responder_array #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .reset(reset),
    .we(done && rwQ == RW_WRITE && !oorQ),
    .re(done && rwQ == RW_READ),
    .zero(oorQ),
    .addr(addrQ),
    .wdata(wdataQ),
    .rdata(RData)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (DEPTH=128, LATENCY=2)
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] Addr = '0;
  logic RW = 1'b0;
  logic Valid = 1'b0;
  logic [31:0] WData = '0;
  logic [31:0] RData;
  logic Ready, Busy, Err;
`ifdef MEM_RESPONDER_WAITSTATE_EN
  logic [3:0] WaitCycles = '0;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct packed {logic [31:0] rd; logic err;} exp_t;
  exp_t q[$];
  logic readyPrev = 1'b0;

  mem_responder #(.DWIDTH(32), .AWIDTH(8), .DEPTH(128), .LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .Addr(Addr),
    .RW(RW),
    .Valid(Valid),
    .WData(WData),
`ifdef MEM_RESPONDER_WAITSTATE_EN
    .WaitCycles(WaitCycles),
`endif
    .RData(RData),
    .Ready(Ready),
    .Busy(Busy),
    .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every rising Ready completes one access and must match the oldest expectation
  always @(negedge clk) begin
    if (Ready && !readyPrev) begin
      if (q.size() == 0) check("unexpected_ready", 32'(Ready), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("rdata", RData, e.rd);
        check("err", 32'(Err), 32'(e.err));
      end
    end
    readyPrev = Ready;
  end

  task automatic txn(input logic [7:0] a, input logic rw, input logic [31:0] wd,
                     input int hold, input int wc, input int expEdges);
    int n;
    @(negedge clk);
    Addr = a;
    RW = rw;
    WData = wd;
    Valid = 1'b1;
`ifdef MEM_RESPONDER_WAITSTATE_EN
    WaitCycles = 4'(wc);
`else
    if (wc != 0) $display("note: WaitCycles %0d ignored in this build", wc);
`endif
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        check("accept_ready_clear", 32'(Ready), 32'd0);
        check("accept_err_clear", 32'(Err), 32'd0);
        check("accept_busy", 32'(Busy), 32'd1);
      end
      if (n >= hold) Valid = 1'b0;
    end while (!Ready && n < 40);
    check("latency_edges", 32'(n), 32'(expEdges));
    check("busy_done", 32'(Busy), 32'd0);
  endtask

  task automatic abortTxn(input logic [7:0] a, input logic rw, input logic [31:0] wd);
    @(negedge clk);
    Addr = a;
    RW = rw;
    WData = wd;
    Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Valid = 1'b0;
    check("abort_busy", 32'(Busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #12;
    check("reset_ready", 32'(Ready), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_err", 32'(Err), 32'd0);
    check("reset_rdata", RData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    q.push_back('{32'h0, 1'b0});
    txn(8'h10, 1'b0, 32'hDEADBEEF, 1, 0, 4);
    q.push_back('{32'hDEADBEEF, 1'b0});
    txn(8'h10, 1'b1, 32'h0, 1, 0, 4);
    repeat (3) @(negedge clk);
    check("ready_level", 32'(Ready), 32'd1);
    q.push_back('{32'hDEADBEEF, 1'b0});
    txn(8'h11, 1'b0, 32'h0000CAFE, 1, 0, 4);
    q.push_back('{32'h0000CAFE, 1'b0});
    txn(8'h11, 1'b1, 32'h0, 6, 0, 7);
    repeat (2) @(negedge clk);
    check("long_valid_single", 32'(Ready), 32'd1);
    q.push_back('{32'h0000CAFE, 1'b0});
    txn(8'd72, 1'b0, 32'h72727272, 1, 0, 4);
    q.push_back('{32'h0000CAFE, 1'b1});
    txn(8'd200, 1'b0, 32'h00001234, 1, 0, 4);
    q.push_back('{32'h72727272, 1'b0});
    txn(8'd72, 1'b1, 32'h0, 1, 0, 4);
    q.push_back('{32'h0, 1'b1});
    txn(8'd200, 1'b1, 32'h0, 1, 0, 4);
    q.push_back('{32'hDEADBEEF, 1'b0});
    txn(8'h10, 1'b1, 32'h0, 1, 0, 4);
    abortTxn(8'h05, 1'b1, 32'h0);
    q.push_back('{32'h0, 1'b0});
    txn(8'h20, 1'b0, 32'h11111111, 1, 0, 4);
    abortTxn(8'h20, 1'b0, 32'h00000055);
    q.push_back('{32'h11111111, 1'b0});
    txn(8'h20, 1'b1, 32'h0, 1, 0, 4);
`ifdef MEM_RESPONDER_WAITSTATE_EN
    q.push_back('{32'hDEADBEEF, 1'b0});
    txn(8'h10, 1'b1, 32'h0, 1, 3, 7);
    q.push_back('{32'h11111111, 1'b0});
    txn(8'h20, 1'b1, 32'h0, 1, 0, 4);
`endif
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
